retire_unit: RTL and testbench

RETIRE_UNIT -- requirements
Module: retire_unit

---
 rtl/retire_unit.sv | 205 ++++++++++++++++++++
 tb/tb_retire_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_unit.sv
`default_nettype none
// retire_unit: final pipeline stage. Drops results from a stale branch epoch,
// writes back ALU/branch results, performs loads/stores and redirects fetch.
// Revision: 1.0
module retire_unit #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [2:0]       xu_sel,
   input  logic [2:0]       i_in,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             wb_in,
   input  logic [31:0]      result,
   input  logic [31:0]      store_data,
   input  logic             jump_in,
   input  logic [31:0]      jump_target,
   output logic             we_out,
   output logic [31:0]      wr_data,
   output logic             jump_out,
   output logic [31:0]      jump_pc,
   output logic [TAG_W-1:0] tag_out,
   output logic             mem_req,
   output logic [3:0]       mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ack
);

   localparam logic [2:0] XU_BRANCH = 3'd4;
   localparam logic [2:0] XU_MEMORY = 3'd5;

   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LW  = 3'd2;
   localparam logic [2:0] OP_LBU = 3'd3;
   localparam logic [2:0] OP_LHU = 3'd4;
   localparam logic [2:0] OP_SB  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SW  = 3'd7;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      LOAD_WB  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
   logic             we_q, we_d;
   logic [31:0]      wr_data_q, wr_data_d;
   logic             jump_q, jump_d;
   logic [31:0]      jump_pc_q, jump_pc_d;
   logic [3:0]       mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic [2:0]       op_q, op_d;
   logic [1:0]       lane_q, lane_d;
   logic             wb_q, wb_d;

   logic             accept;
   logic             is_store;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      ld_data;

   assign accept   = valid_in && (state_q == IDLE) && (tag_in == cur_tag_q);
   assign is_store = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);

   // Lane extraction uses the byte offset captured at acceptance, since
   // mem_addr itself is word aligned.
   always_comb begin
      ld_byte = mem_rdata[7:0];
      case (lane_q)
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         2'd3:    ld_byte = mem_rdata[31:24];
         default: ld_byte = mem_rdata[7:0];
      endcase
      ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (op_q)
         OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
         OP_LBU:  ld_data = {24'd0, ld_byte};
         OP_LHU:  ld_data = {16'd0, ld_half};
         OP_LW:   ld_data = mem_rdata;
         default: ld_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cur_tag_d   = cur_tag_q;
      we_d        = 1'b0;
      wr_data_d   = wr_data_q;
      jump_d      = 1'b0;
      jump_pc_d   = jump_pc_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      op_d        = op_q;
      lane_d      = lane_q;
      wb_d        = wb_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (xu_sel == XU_MEMORY) begin
                  state_d    = MEM_WAIT;
                  op_d       = i_in;
                  lane_d     = result[1:0];
                  wb_d       = wb_in;
                  mem_addr_d = {result[31:2], 2'b00};
                  case (i_in)
                     OP_SB: begin
                        mem_we_d    = 4'b0001 << result[1:0];
                        mem_wdata_d = {4{store_data[7:0]}};
                     end
                     OP_SH: begin
                        mem_we_d    = 4'b0011 << {result[1], 1'b0};
                        mem_wdata_d = {2{store_data[15:0]}};
                     end
                     OP_SW: begin
                        mem_we_d    = 4'b1111;
                        mem_wdata_d = store_data;
                     end
                     default: begin
                        mem_we_d    = 4'b0000;
                        mem_wdata_d = 32'd0;
                     end
                  endcase
               end else begin
                  we_d      = wb_in;
                  wr_data_d = result;
                  if ((xu_sel == XU_BRANCH) && jump_in) begin
                     jump_d    = 1'b1;
                     jump_pc_d = jump_target;
                     // Epoch advances with the redirect; wraps naturally.
                     cur_tag_d = cur_tag_q + {{(TAG_W-1){1'b0}}, 1'b1};
                  end
               end
            end
         end
         MEM_WAIT: begin
            if (mem_ack) begin
               if (is_store) begin
                  state_d = IDLE;
               end else begin
                  state_d   = LOAD_WB;
                  we_d      = wb_q;
                  wr_data_d = ld_data;
               end
            end
         end
         LOAD_WB: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cur_tag_q   <= '0;
         we_q        <= 1'b0;
         wr_data_q   <= 32'd0;
         jump_q      <= 1'b0;
         jump_pc_q   <= 32'd0;
         mem_we_q    <= 4'd0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         op_q        <= 3'd0;
         lane_q      <= 2'd0;
         wb_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_tag_q   <= cur_tag_d;
         we_q        <= we_d;
         wr_data_q   <= wr_data_d;
         jump_q      <= jump_d;
         jump_pc_q   <= jump_pc_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         op_q        <= op_d;
         lane_q      <= lane_d;
         wb_q        <= wb_d;
      end
   end

   assign ready_out = (state_q == IDLE);
   assign mem_req   = (state_q == MEM_WAIT);
   assign we_out    = we_q;
   assign wr_data   = wr_data_q;
   assign jump_out  = jump_q;
   assign jump_pc   = jump_pc_q;
   assign tag_out   = cur_tag_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_retire_unit.sv
`default_nettype none
// tb_retire_unit: directed scenarios followed by random traffic, every cycle
// compared against a transaction-level reference model.
// Revision: 1.0
module tb_retire_unit;

   logic        clk = 1'b0;
   logic        reset, valid_in, ready_out, wb_in, jump_in;
   logic [2:0]  xu_sel, i_in;
   logic [3:0]  tag_in, tag_out;
   logic [31:0] result, store_data, jump_target;
   logic        we_out, jump_out, mem_req, mem_ack;
   logic [31:0] wr_data, jump_pc, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_we;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: epoch counter plus the one outstanding memory
   // transaction (phase 0 none, 1 awaiting ack, 2 load write-back cycle).
   int          m_phase;
   int unsigned m_tag;
   int unsigned m_op;
   logic [31:0] m_addr, m_sd;
   logic        m_wb, m_rst;
   logic        exp_we, exp_jump;
   logic [31:0] exp_wr, exp_jpc;

   always #5 clk = ~clk;

   retire_unit #(.TAG_W(4)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
      .xu_sel(xu_sel), .i_in(i_in), .tag_in(tag_in), .wb_in(wb_in),
      .result(result), .store_data(store_data), .jump_in(jump_in),
      .jump_target(jump_target), .we_out(we_out), .wr_data(wr_data),
      .jump_out(jump_out), .jump_pc(jump_pc), .tag_out(tag_out),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_load(input int unsigned op, input logic [31:0] a, input logic [31:0] rd);
      logic [31:0] v;
      int unsigned off;
      case (op)
         0, 3: begin
            off = a % 4;
            v = (rd >> (8 * off)) & 32'hFF;
            if (op == 0 && v >= 128) v = v | 32'hFFFF_FF00;
         end
         1, 4: begin
            off = ((a % 4) / 2) * 2;
            v = (rd >> (8 * off)) & 32'hFFFF;
            if (op == 1 && v >= 32768) v = v | 32'hFFFF_0000;
         end
         default: v = rd;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] ref_strobe(input int unsigned op, input logic [31:0] a);
      case (op)
         5:       return 32'(1 << (a % 4));
         6:       return 32'(3 << (((a % 4) / 2) * 2));
         7:       return 32'd15;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] ref_wdata(input int unsigned op, input logic [31:0] sd);
      case (op)
         5:       return (sd & 32'hFF) * 32'h0101_0101;
         6:       return (sd & 32'hFFFF) * 32'h0001_0001;
         7:       return sd;
         default: return 32'd0;
      endcase
   endfunction

   // Advance the model across one clock edge using the inputs now applied.
   task automatic model_edge();
      exp_we   = 1'b0;
      exp_jump = 1'b0;
      m_rst    = 1'b0;
      if (reset) begin
         m_rst = 1'b1;
         m_tag = 0;
         m_phase = 0;
      end else if (m_phase == 0) begin
         if (valid_in && tag_in == 4'(m_tag)) begin
            if (xu_sel == 3'd5) begin
               m_phase = 1;
               m_op    = i_in;
               m_addr  = result;
               m_sd    = store_data;
               m_wb    = wb_in;
            end else begin
               exp_we = wb_in;
               exp_wr = result;
               if (xu_sel == 3'd4 && jump_in) begin
                  exp_jump = 1'b1;
                  exp_jpc  = jump_target;
                  m_tag    = (m_tag + 1) % 16;
               end
            end
         end
      end else if (m_phase == 1) begin
         if (mem_ack) begin
            if (m_op >= 5) m_phase = 0;
            else begin
               m_phase = 2;
               exp_we  = m_wb;
               exp_wr  = ref_load(m_op, m_addr, mem_rdata);
            end
         end
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic check_all();
      check_eq("ready_out", 32'(ready_out), 32'(m_phase == 0));
      check_eq("we_out", 32'(we_out), 32'(exp_we));
      if (exp_we) check_eq("wr_data", wr_data, exp_wr);
      check_eq("jump_out", 32'(jump_out), 32'(exp_jump));
      if (exp_jump) check_eq("jump_pc", jump_pc, exp_jpc);
      check_eq("tag_out", 32'(tag_out), m_tag);
      check_eq("mem_req", 32'(mem_req), 32'(m_phase == 1));
      if (m_phase == 1) begin
         check_eq("mem_addr", mem_addr, m_addr & 32'hFFFF_FFFC);
         check_eq("mem_we", 32'(mem_we), ref_strobe(m_op, m_addr));
         if (m_op >= 5) check_eq("mem_wdata", mem_wdata, ref_wdata(m_op, m_sd));
      end
      if (m_rst) begin
         check_eq("rst_wr_data", wr_data, 32'd0);
         check_eq("rst_jump_pc", jump_pc, 32'd0);
         check_eq("rst_mem_we", 32'(mem_we), 32'd0);
         check_eq("rst_mem_addr", mem_addr, 32'd0);
         check_eq("rst_mem_wdata", mem_wdata, 32'd0);
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle_in();
      reset = 1'b0; valid_in = 1'b0; xu_sel = 3'd0; i_in = 3'd0; tag_in = 4'd0;
      wb_in = 1'b0; result = 32'd0; store_data = 32'd0; jump_in = 1'b0;
      jump_target = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
   endtask

   task automatic issue(input logic [2:0] xu, input logic [2:0] op, input logic wb,
                        input logic [31:0] res, input logic [31:0] sd,
                        input logic jmp, input logic [31:0] tgt);
      idle_in();
      valid_in = 1'b1; xu_sel = xu; i_in = op; wb_in = wb; result = res;
      store_data = sd; jump_in = jmp; jump_target = tgt; tag_in = 4'(m_tag);
      step();
      idle_in();
   endtask

   initial begin
      m_phase = 0; m_tag = 0; m_op = 0; m_addr = 0; m_sd = 0; m_wb = 0;
      exp_wr = 0; exp_jpc = 0;
      idle_in();
      @(posedge clk); #1;
      reset = 1'b1;
      step();
      reset = 1'b0;

      // Plain adder write-back.
      issue(3'd1, 3'd0, 1'b1, 32'h0000_1234, 32'd0, 1'b0, 32'd0);
      check_eq("add_we", 32'(we_out), 32'd1);
      check_eq("add_data", wr_data, 32'h0000_1234);
      check_eq("add_ready", 32'(ready_out), 32'd1);

      // Taken JAL-style branch, then a stale-epoch result.
      issue(3'd4, 3'd0, 1'b1, 32'h0000_0104, 32'd0, 1'b1, 32'h0000_0200);
      check_eq("br_jump", 32'(jump_out), 32'd1);
      check_eq("br_pc", jump_pc, 32'h0000_0200);
      check_eq("br_link", wr_data, 32'h0000_0104);
      check_eq("br_tag", 32'(tag_out), 32'd1);
      idle_in();
      valid_in = 1'b1; xu_sel = 3'd1; wb_in = 1'b1; result = 32'h55; tag_in = 4'd0;
      step();
      check_eq("stale_we", 32'(we_out), 32'd0);
      idle_in();

      // Signed and unsigned byte loads with a three-cycle ack.
      for (int k = 0; k < 2; k++) begin
         issue(3'd5, (k == 0) ? 3'd0 : 3'd3, 1'b1, 32'h0000_1003, 32'd0, 1'b0, 32'd0);
         check_eq("ld_addr", mem_addr, 32'h0000_1000);
         step();
         step();
         mem_ack = 1'b1; mem_rdata = 32'h80FF_FF7F;
         step();
         idle_in();
         check_eq("ld_we", 32'(we_out), 32'd1);
         check_eq("ld_data", wr_data, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
         step();
      end

      // Halfword store to the upper lane.
      issue(3'd5, 3'd6, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 1'b0, 32'd0);
      check_eq("sh_we", 32'(mem_we), 32'hC);
      check_eq("sh_wdata", mem_wdata, 32'hABCD_ABCD);
      check_eq("sh_ready", 32'(ready_out), 32'd0);
      mem_ack = 1'b1;
      step();
      idle_in();
      check_eq("sh_no_wb", 32'(we_out), 32'd0);

      // Reset in the middle of a load; the late ack must be ignored.
      issue(3'd5, 3'd2, 1'b1, 32'h0000_3000, 32'd0, 1'b0, 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("abort_req", 32'(mem_req), 32'd0);
      check_eq("abort_ready", 32'(ready_out), 32'd1);
      step();
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      step();
      mem_ack = 1'b0;
      check_eq("late_ack_we", 32'(we_out), 32'd0);

      // Sixteen taken branches wrap the epoch back to zero.
      for (int k = 0; k < 16; k++)
         issue(3'd4, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h100 + 32'(k));
      check_eq("wrap_tag", 32'(tag_out), 32'd0);
      issue(3'd2, 3'd0, 1'b1, 32'h0000_0777, 32'd0, 1'b0, 32'd0);
      check_eq("wrap_accept", 32'(we_out), 32'd1);

      // Random traffic.
      for (int n = 0; n < 4000; n++) begin
         reset       = ($urandom_range(0, 199) == 0);
         valid_in    = ($urandom_range(0, 9) < 6);
         xu_sel      = 3'($urandom_range(0, 5));
         if ($urandom_range(0, 3) == 0) xu_sel = 3'd5;
         i_in        = 3'($urandom);
         tag_in      = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(m_tag);
         wb_in       = 1'($urandom);
         jump_in     = 1'($urandom);
         result      = $urandom;
         store_data  = $urandom;
         jump_target = $urandom;
         mem_rdata   = $urandom;
         mem_ack     = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
